fetch_inst_queue: RTL

- Decoupling FIFO between Fetch (upstream) and Decode (downstream).
- Absorbs Decode stalls so Fetch keeps streaming up to DEPTH instructions ahead, preserving program order.
- Supports a single-cycle flush for branch/exception redirect.
- Both sides use the same valid/ready handshake that Fetch exposes.

---
 rtl/fetch_inst_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_inst_queue.sv
// ----------------------------------------------------------------------------
// fetch_inst_queue
//
// Decoupling FIFO between Fetch (upstream) and Decode (downstream). It buffers
// up to DEPTH instructions so Fetch can keep streaming while Decode stalls.
// Program order is preserved. A single-cycle flush discards every entry when a
// branch or exception redirects the front end.
//
// There is no fall-through path. An instruction enqueued at edge N is first
// visible on valid_o in the cycle after edge N. Both sides use the same
// valid/ready handshake that Fetch exposes.
//
// Ports:
//   clk      in   1            clock, rising edge
//   reset    in   1            asynchronous, active-high reset
//   flush_i  in   1            synchronous flush, discards all entries
//   valid_i  in   1            Fetch presents an instruction
//   ready_o  out  1            queue can accept an instruction (count != DEPTH)
//   pc_i     in   PC_WIDTH     PC of the incoming instruction
//   inst_i   in   DATA_WIDTH   incoming instruction word
//   valid_o  out  1            head entry valid toward Decode (count != 0)
//   ready_i  in   1            Decode accepts the head entry
//   pc_o     out  PC_WIDTH     PC of the head entry, 0 when empty
//   inst_o   out  DATA_WIDTH   instruction of the head entry, 0 when empty
//   count_o  out  clog2(D)+1   current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_inst_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [PC_WIDTH-1:0]      pc_i,
    input  logic [DATA_WIDTH-1:0]    inst_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [PC_WIDTH-1:0]      pc_o,
    output logic [DATA_WIDTH-1:0]    inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Pointers wrap naturally because DEPTH is a power of two.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_inst_queue: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    // Storage is never reset. Only the pointers and the count define which
    // entries are live.
    logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic enq;
    logic deq;
    logic wr_en;

    // ------------------------------------------------------------------
    // Outputs are decoded from registered state only. ready_o never looks
    // at ready_i, so a full queue does not accept a new entry even when
    // Decode drains one in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        ready_o = (count_q != CNT_FULL);
        valid_o = (count_q != '0);
        count_o = count_q;
        pc_o    = '0;
        inst_o  = '0;
        if (valid_o) begin
            pc_o   = pc_mem_q[rd_ptr_q];
            inst_o = inst_mem_q[rd_ptr_q];
        end
    end

    assign enq   = valid_i & ready_o;
    assign deq   = valid_o & ready_i;
    // An enqueue that collides with a flush is dropped. A dequeue in the
    // flush cycle has already been consumed by Decode, so nothing else
    // needs to be done for it.
    assign wr_en = enq & ~flush_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]   <= pc_i;
            inst_mem_q[wr_ptr_q] <= inst_i;
        end
    end

endmodule
